// File: rtl/jpeg_block_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : jpeg_block_sequencer
//  Purpose  : Buffers one 8x8 RGB block and bursts it into jpeg_top, with an
//             inter-block gap, EOF flagging and a bounded final flush.
//  Option   : JPEG_SEQ_STALL_CNT_EN adds the stall_cnt starvation counter.
//  Revision : 1.0 - initial release
// ============================================================================
module jpeg_block_sequencer #(
   parameter int PIX_W         = 24,
   parameter int BLOCK_PIX     = 64,
   parameter int GAP_CYCLES    = 40,
   parameter int FLUSH_TIMEOUT = 4096
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [PIX_W-1:0] s_data,
   input  logic             s_last,
   output logic             enc_enable,
   output logic [PIX_W-1:0] enc_data,
   output logic             enc_eof,
   input  logic             enc_data_ready,
   input  logic             enc_eof_partial,
   output logic             busy,
   output logic             done,
   output logic [15:0]      blk_count,
   output logic [19:0]      word_count,
   output logic             pad_err,
`ifdef JPEG_SEQ_STALL_CNT_EN
   output logic [31:0]      stall_cnt,
`endif
   output logic             flush_to
);

   localparam int PTR_W   = $clog2(BLOCK_PIX);
   localparam int CNT_MAX = (FLUSH_TIMEOUT > GAP_CYCLES) ? FLUSH_TIMEOUT : GAP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BLOCK_PIX - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL  = 3'd1,
      S_PAD   = 3'd2,
      S_BURST = 3'd3,
      S_GAP   = 3'd4,
      S_FLUSH = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               final_q, final_d;
   logic [PIX_W-1:0]   pad_val_q, pad_val_d;
   logic               s_ready_q, s_ready_d;
   logic               busy_q, busy_d, done_q, done_d;
   logic [15:0]        blk_cnt_q, blk_cnt_d;
   logic [19:0]        word_cnt_q, word_cnt_d;
   logic               pad_err_q, pad_err_d, flush_to_q, flush_to_d;
   logic               enc_enable_q, enc_enable_d, enc_eof_q, enc_eof_d;
   logic [PIX_W-1:0]   enc_data_q, enc_data_d;
   logic               buf_we;
   logic [PIX_W-1:0]   buf_wdata;
   logic [PIX_W-1:0]   mem_q [BLOCK_PIX];

   // Block storage carries no reset: contents are only read after a full refill.
   always_ff @(posedge clk) begin
      if (buf_we) mem_q[wr_ptr_q] <= buf_wdata;
   end

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      cnt_d        = cnt_q;
      final_d      = final_q;
      pad_val_d    = pad_val_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      blk_cnt_d    = blk_cnt_q;
      word_cnt_d   = word_cnt_q;
      pad_err_d    = pad_err_q;
      flush_to_d   = flush_to_q;
      enc_enable_d = 1'b0;
      enc_data_d   = enc_data_q;
      enc_eof_d    = 1'b0;
      buf_we       = 1'b0;
      buf_wdata    = s_data;

      if (busy_q && enc_data_ready && (word_cnt_q != '1)) word_cnt_d = word_cnt_q + 20'd1;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_FILL;
               busy_d     = 1'b1;
               wr_ptr_d   = '0;
               rd_ptr_d   = '0;
               final_d    = 1'b0;
               blk_cnt_d  = '0;
               word_cnt_d = '0;
               pad_err_d  = 1'b0;
               flush_to_d = 1'b0;
            end
         end
         S_FILL: begin
            if (s_valid && s_ready_q) begin
               buf_we   = 1'b1;
               wr_ptr_d = wr_ptr_q + PTR_W'(1);
               if (wr_ptr_q == LAST_PTR) begin
                  final_d  = s_last;
                  rd_ptr_d = '0;
                  state_d  = S_BURST;
               end else if (s_last) begin
                  pad_val_d = s_data;
                  pad_err_d = 1'b1;
                  state_d   = S_PAD;
               end
            end
         end
         S_PAD: begin
            buf_we    = 1'b1;
            buf_wdata = pad_val_q;
            wr_ptr_d  = wr_ptr_q + PTR_W'(1);
            if (wr_ptr_q == LAST_PTR) begin
               final_d  = 1'b1;
               rd_ptr_d = '0;
               state_d  = S_BURST;
            end
         end
         S_BURST: begin
            enc_enable_d = 1'b1;
            enc_data_d   = mem_q[rd_ptr_q];
            enc_eof_d    = final_q && (rd_ptr_q == '0);
            if ((rd_ptr_q == '0) && (blk_cnt_q != '1)) blk_cnt_d = blk_cnt_q + 16'd1;
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (rd_ptr_q == LAST_PTR) begin
               cnt_d   = '0;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
               cnt_d    = '0;
               wr_ptr_d = '0;
               state_d  = final_q ? S_FLUSH : S_FILL;
            end
         end
         S_FLUSH: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (enc_eof_partial) begin
               state_d = S_DONE;
            end else if (cnt_q == CNT_W'(FLUSH_TIMEOUT - 1)) begin
               flush_to_d = 1'b1;
               state_d    = S_DONE;
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      s_ready_d = (state_d == S_FILL);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
         final_q      <= 1'b0;
         pad_val_q    <= '0;
         s_ready_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         blk_cnt_q    <= '0;
         word_cnt_q   <= '0;
         pad_err_q    <= 1'b0;
         flush_to_q   <= 1'b0;
         enc_enable_q <= 1'b0;
         enc_data_q   <= '0;
         enc_eof_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
         final_q      <= final_d;
         pad_val_q    <= pad_val_d;
         s_ready_q    <= s_ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         blk_cnt_q    <= blk_cnt_d;
         word_cnt_q   <= word_cnt_d;
         pad_err_q    <= pad_err_d;
         flush_to_q   <= flush_to_d;
         enc_enable_q <= enc_enable_d;
         enc_data_q   <= enc_data_d;
         enc_eof_q    <= enc_eof_d;
      end
   end

`ifdef JPEG_SEQ_STALL_CNT_EN
   logic [31:0] stall_q, stall_d;

   // Counts FILL cycles where the source had nothing to offer.
   always_comb begin
      stall_d = stall_q;
      if ((state_q == S_IDLE) && start) stall_d = '0;
      else if ((state_q == S_FILL) && !s_valid && (stall_q != '1)) stall_d = stall_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) stall_q <= '0;
      else      stall_q <= stall_d;
   end

   assign stall_cnt = stall_q;
`endif

   assign s_ready    = s_ready_q;
   assign enc_enable = enc_enable_q;
   assign enc_data   = enc_data_q;
   assign enc_eof    = enc_eof_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign blk_count  = blk_cnt_q;
   assign word_count = word_cnt_q;
   assign pad_err    = pad_err_q;
   assign flush_to   = flush_to_q;

endmodule
`default_nettype wire

// File: tb/tb_jpeg_block_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jpeg_block_sequencer
//  Purpose  : Directed self-checking bench for jpeg_block_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jpeg_block_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0, s_valid = 1'b0, s_last = 1'b0;
   logic [23:0] s_data = '0;
   logic        enc_data_ready = 1'b0, enc_eof_partial = 1'b0;
   logic        s_ready, enc_enable, enc_eof, busy, done, pad_err, flush_to;
   logic [23:0] enc_data;
   logic [15:0] blk_count;
   logic [19:0] word_count;
`ifdef JPEG_SEQ_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;

   jpeg_block_sequencer dut (
      .clk(clk), .rst(rst), .start(start),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .enc_enable(enc_enable), .enc_data(enc_data), .enc_eof(enc_eof),
      .enc_data_ready(enc_data_ready), .enc_eof_partial(enc_eof_partial),
      .busy(busy), .done(done), .blk_count(blk_count), .word_count(word_count),
      .pad_err(pad_err),
`ifdef JPEG_SEQ_STALL_CNT_EN
      .stall_cnt(stall_cnt),
`endif
      .flush_to(flush_to)
   );

   always #5 clk = ~clk;

   // Burst monitor: captures every enabled beat and the run/gap structure.
   logic [23:0] dq[$];
   int          runs[$];
   int          eof_pos[$];
   int          cur_run, cur_gap, min_gap, stray_eof;
   logic        prev_en;

   always @(negedge clk) begin
      if (enc_enable) begin
         if (!prev_en) begin
            if (runs.size() > 0 && cur_gap < min_gap) min_gap = cur_gap;
            cur_run = 0;
         end
         cur_run++;
         if (enc_eof) eof_pos.push_back(dq.size());
         dq.push_back(enc_data);
      end else begin
         if (prev_en) begin
            runs.push_back(cur_run);
            cur_gap = 0;
         end
         cur_gap++;
         if (enc_eof) stray_eof++;
      end
      prev_en = enc_enable;
   end

   task automatic mon_clear();
      dq.delete(); runs.delete(); eof_pos.delete();
      cur_run = 0; cur_gap = 0; min_gap = 1000000; stray_eof = 0; prev_en = 1'b0;
   endtask

   task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic send_pix(input logic [23:0] d, input logic last);
      int t = 0;
      s_valid = 1'b1; s_data = d; s_last = last;
      while (!s_ready && t < 5000) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 5000) chk_val("sready_wait", 32'(s_ready), 32'd1);
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic send_seq(input int n, input logic [23:0] base, input bit stall);
      for (int i = 0; i < n; i++) begin
         if (stall && $urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
         end
         send_pix(base + 24'(i), (i == n - 1));
      end
   endtask

   task automatic wait_done(output int cycles);
      cycles = 0;
      while (!done && cycles < 6000) begin
         @(posedge clk); #1;
         cycles++;
      end
      chk_val("done_seen", 32'(done), 32'd1);
   endtask

   task automatic do_reset();
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      mon_clear();
   endtask

   initial begin
      int cyc, bad, cnt;
      mon_clear();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Reset state
      chk_val("rst_enable", 32'(enc_enable), 0);
      chk_val("rst_data",   32'(enc_data), 0);
      chk_val("rst_eof",    32'(enc_eof), 0);
      chk_val("rst_sready", 32'(s_ready), 0);
      chk_val("rst_busy",   32'(busy), 0);
      chk_val("rst_done",   32'(done), 0);
      chk_val("rst_blk",    32'(blk_count), 0);
      chk_val("rst_word",   32'(word_count), 0);
      chk_val("rst_flags",  {30'd0, pad_err, flush_to}, 0);

      // 1: single full block, final
      enc_eof_partial = 1'b1;
      mon_clear();
      pulse_start();
      chk_val("t1_busy",   32'(busy), 1);
      chk_val("t1_sready", 32'(s_ready), 1);
      send_seq(64, 24'h000000, 1'b0);
      wait_done(cyc);
      chk_val("t1_busy_at_done", 32'(busy), 0);
      chk_val("t1_gap_ge40", 32'(cur_gap >= 40), 1);
      chk_val("t1_runs", 32'(runs.size()), 1);
      chk_val("t1_runlen", (runs.size() > 0) ? 32'(runs[0]) : 32'hDEAD, 64);
      chk_val("t1_eof_cnt", 32'(eof_pos.size()), 1);
      chk_val("t1_eof_pos", (eof_pos.size() > 0) ? 32'(eof_pos[0]) : 32'hDEAD, 0);
      bad = 0;
      for (int i = 0; i < dq.size(); i++) if (dq[i] !== 24'(i)) bad++;
      chk_val("t1_data", 32'(bad), 0);
      chk_val("t1_blk", 32'(blk_count), 1);
      chk_val("t1_pad_err", 32'(pad_err), 0);
      chk_val("t1_flush_to", 32'(flush_to), 0);
      chk_val("t1_word", 32'(word_count), 0);
      @(posedge clk); #1;
      chk_val("t1_done_pulse", 32'(done), 0);

      // 2: two full blocks
      mon_clear();
      pulse_start();
      send_seq(128, 24'h000000, 1'b0);
      wait_done(cyc);
      chk_val("t2_runs", 32'(runs.size()), 2);
      chk_val("t2_run0", (runs.size() > 0) ? 32'(runs[0]) : 32'hDEAD, 64);
      chk_val("t2_run1", (runs.size() > 1) ? 32'(runs[1]) : 32'hDEAD, 64);
      chk_val("t2_gap_ge40", 32'(min_gap >= 40), 1);
      chk_val("t2_eof_cnt", 32'(eof_pos.size()), 1);
      chk_val("t2_eof_pos", (eof_pos.size() > 0) ? 32'(eof_pos[0]) : 32'hDEAD, 64);
      chk_val("t2_stray_eof", 32'(stray_eof), 0);
      bad = 0;
      for (int i = 0; i < dq.size(); i++) if (dq[i] !== 24'(i)) bad++;
      chk_val("t2_data", 32'(bad + (dq.size() != 128)), 0);
      chk_val("t2_blk", 32'(blk_count), 2);

      // 3: short image padded with last pixel
      mon_clear();
      pulse_start();
      for (int i = 0; i < 9; i++) send_pix(24'h000100 + 24'(i), 1'b0);
      send_pix(24'hABCDEF, 1'b1);
      wait_done(cyc);
      bad = 0; cnt = 0;
      for (int i = 0; i < dq.size(); i++) begin
         if (i < 9 && dq[i] !== 24'h000100 + 24'(i)) bad++;
         if (i >= 9 && dq[i] !== 24'hABCDEF) bad++;
         if (i >= 10 && dq[i] === 24'hABCDEF) cnt++;
      end
      chk_val("t3_data", 32'(bad + (dq.size() != 64)), 0);
      chk_val("t3_pad_copies", 32'(cnt), 54);
      chk_val("t3_pad_err", 32'(pad_err), 1);
      chk_val("t3_eof_pos", (eof_pos.size() > 0) ? 32'(eof_pos[0]) : 32'hDEAD, 0);
      chk_val("t3_blk", 32'(blk_count), 1);

      // 4: stalling source plus 7 data_ready cycles
      mon_clear();
      pulse_start();
      fork
         send_seq(64, 24'h5A0000, 1'b1);
         begin
            for (int k = 0; k < 7; k++) begin
               @(posedge clk); #1 enc_data_ready = 1'b1;
               @(posedge clk); #1 enc_data_ready = 1'b0;
            end
         end
      join
      wait_done(cyc);
      chk_val("t4_runs", 32'(runs.size()), 1);
      chk_val("t4_runlen", (runs.size() > 0) ? 32'(runs[0]) : 32'hDEAD, 64);
      bad = 0;
      for (int i = 0; i < dq.size(); i++) if (dq[i] !== 24'h5A0000 + 24'(i)) bad++;
      chk_val("t4_data", 32'(bad), 0);
      chk_val("t4_word", 32'(word_count), 7);
      chk_val("t4_pad_err_cleared", 32'(pad_err), 0);

      // 5a: flush timeout
      enc_eof_partial = 1'b0;
      mon_clear();
      pulse_start();
      send_seq(64, 24'h000000, 1'b0);
      wait_done(cyc);
      chk_val("t5_flush_to", 32'(flush_to), 1);
      chk_val("t5_wait_ge", 32'(cyc >= 4200), 1);
      chk_val("t5_blk", 32'(blk_count), 1);

      // 5b: reset mid-burst
      mon_clear();
      pulse_start();
      send_seq(64, 24'h000000, 1'b0);
      repeat (10) @(posedge clk);
      #1 chk_val("t5_midburst_en", 32'(enc_enable), 1);
      #2 rst = 1'b0;
      #1 chk_val("t5_async_en", 32'(enc_enable), 0);
      chk_val("t5_async_busy", 32'(busy), 0);
      @(posedge clk); @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      chk_val("t5_idle_sready", 32'(s_ready), 0);
      chk_val("t5_idle_blk", 32'(blk_count), 0);
      chk_val("t5_idle_en", 32'(enc_enable), 0);
      pulse_start();
      chk_val("t5_restart_sready", 32'(s_ready), 1);
      do_reset();

`ifdef JPEG_SEQ_STALL_CNT_EN
      // 6: source starvation counter
      pulse_start();
      repeat (25) @(posedge clk);
      #1 chk_val("t6_stall", stall_cnt, 25);
      do_reset();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/jpeg_block_sequencer.md
Name: jpeg_block_sequencer

Overview:
Sequences pixel delivery into the jpeg_top encoder core. It accepts a valid/ready RGB pixel stream, buffers one 8x8 block (64 pixels), and bursts it into the core on consecutive cycles with enable high. It inserts the required inter-block idle gap, flags the final block via end-of-file, then waits for the core's final partial word before reporting completion. It sits between the pixel source (DMA/line buffer) and jpeg_top, and also monitors the core's output handshake.

Parameters:
PIX_W, 24, pixel width (8b R, G, B packed).
BLOCK_PIX, 64, pixels per block; buffer depth.
GAP_CYCLES, 40, idle cycles with enc_enable low after each burst.
FLUSH_TIMEOUT, 4096, max cycles waiting for enc_eof_partial after the final burst.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse that begins an image; ignored unless IDLE
s_valid  in  1  source pixel valid
s_ready  out  1  sequencer accepts a pixel
s_data  in  PIX_W  source pixel
s_last  in  1  marks the last pixel of the image
enc_enable  out  1  drives jpeg_top enable
enc_data  out  PIX_W  drives jpeg_top data_in
enc_eof  out  1  drives jpeg_top end_of_file_signal
enc_data_ready  in  1  from jpeg_top data_ready
enc_eof_partial  in  1  from jpeg_top eof_data_partial_ready
busy  out  1  high from start acceptance until done
done  out  1  one-cycle completion pulse
blk_count  out  16  blocks issued this image
word_count  out  20  enc_data_ready cycles counted this image
pad_err  out  1  sticky flag: image ended mid-block, so padding was applied
flush_to  out  1  sticky flag: flush ended by timeout

Behaviour:
- Reset (rst=0, async): all outputs 0, state IDLE, pointers 0. Reset mid-burst drops enc_enable on the same edge and discards buffer contents.
- Outputs are registered. enc_data and enc_enable change together.
- IDLE: s_ready=0. On start, clear counters and sticky flags, set busy=1, and go to FILL.
- FILL: s_ready=1. Each handshake (s_valid & s_ready) writes buf[wr_ptr] and increments wr_ptr.
  - Handshake at wr_ptr=63 goes to BURST.
  - Handshake with s_last and wr_ptr<63 latches the pixel as pad value, sets pad_err, and goes to PAD.
  - s_last with wr_ptr=63 marks the block final.
- PAD: s_ready=0. Writes the pad value one entry per cycle until wr_ptr=63 is written, then goes to BURST with final=1.
- BURST: s_ready=0. enc_enable=1 for exactly 64 consecutive cycles with enc_data=buf[0..63] in order.
  - enc_eof=1 only on the first burst cycle of the final block.
  - blk_count increments on the first burst cycle and saturates at 0xFFFF.
- GAP: enc_enable=0 and enc_data holds its last value for GAP_CYCLES cycles. Then go to FLUSH if final, else FILL with wr_ptr=0.
- FLUSH: wait for enc_eof_partial=1 and go to DONE. If FLUSH_TIMEOUT cycles elapse first, set flush_to and go to DONE.
- DONE: done=1 for one cycle, busy=0, return to IDLE. Counters hold until the next start.
- word_count increments on every cycle with enc_data_ready=1 while busy=1 (including FLUSH), and saturates.
- If enc_data_ready and enc_eof_partial arrive in the same cycle, the word is counted and FLUSH exits.
- s_valid during IDLE, BURST, GAP, PAD or FLUSH has no effect because s_ready=0.
- A start pulse while busy is ignored.

Optional Feature:
JPEG_SEQ_STALL_CNT_EN:
- Defined: adds output stall_cnt[31:0], reset and cleared on start. It increments on each cycle with state=FILL and s_valid=0 (source starvation), and saturates.
- Undefined: no port and no logic.

Test Plan:
1. Reset, start, then 64 pixels 0x000000..0x00003F with s_last on the 64th -> one 64-cycle burst, enc_eof=1 on the first cycle with enc_data=0x000000, 40 gap cycles, then FLUSH. Drive enc_eof_partial -> done pulse, blk_count=1, pad_err=0.
2. 128 pixels as two full blocks -> two bursts separated by ≥40 idle cycles; enc_eof only on the second burst's first cycle; blk_count=2.
3. 10 pixels with s_last on the 10th (value 0xABCDEF) -> PAD fills entries 10..63 with 0xABCDEF, burst shows 54 copies, pad_err=1.
4. Toggle s_valid randomly during FILL and drive enc_data_ready for 7 cycles -> burst is still contiguous 64 cycles, word_count=7.
5. Never assert enc_eof_partial -> done after 4096 FLUSH cycles with flush_to=1. Separately, assert rst low mid-burst -> enc_enable=0 immediately and state is IDLE after release.
6. With JPEG_SEQ_STALL_CNT_EN defined, hold s_valid low 25 cycles in FILL -> stall_cnt=25.
